// File: rtl/Types.sv
// Types: shared widths, constants and record layouts for the reorder buffer slice.
//
// Contents:
//   ROB_DEPTH, RN_W      ROB entry count (16) and ROB number width (4)
//   PREG_W, DATA_W       physical register address width and result width
//   NUM_FU               number of completion ports (FU1, FU2, FU3-mem)
//   rob_num_t            ROB number type
//   rob_row_struct       one ROB entry as stored in the entry array
//   complete_stage_struct one completion port as seen from the complete stage
package Types;

  localparam int ROB_DEPTH = 16;
  localparam int RN_W      = 4;
  localparam int PREG_W    = 7;
  localparam int DATA_W    = 32;
  localparam int NUM_FU    = 3;

  // Occupancy value at which the ROB is full; one bit wider than a ROB number.
  localparam logic [RN_W:0] ROB_FULL_COUNT = 5'd16;

  typedef logic [3:0]        rob_num_t;
  typedef logic [PREG_W-1:0] preg_t;

  typedef struct packed {
    logic              valid;
    logic              complete;
    preg_t             preg_dst;
    preg_t             old_preg_dst;
    logic [DATA_W-1:0] data;
    logic              reg_write;
    logic              mem_write;
  } rob_row_struct;

  typedef struct packed {
    rob_num_t          ROBNumber;
    logic [DATA_W-1:0] FU_Result;
  } complete_stage_struct;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// rob_ptr_ctrl: head/tail pointers and occupancy counter of the reorder buffer.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         (only with ROB_FLUSH_EN) synchronous clear of pointers and count
//   alloc_fire    an entry is written at tail this cycle
//   retire_fire   the head entry leaves this cycle
//   head, tail    oldest entry / next entry to allocate (wrap naturally)
//   count         occupied entries, 0..ROB_DEPTH
//   full, empty   status decoded from count
//
// Optional feature macro: ROB_FLUSH_EN
module rob_ptr_ctrl
  import Types::*;
(
  input  logic            clk,
  input  logic            rst_n,
`ifdef ROB_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            alloc_fire,
  input  logic            retire_fire,
  output logic [RN_W-1:0] head,
  output logic [RN_W-1:0] tail,
  output logic [RN_W:0]   count,
  output logic            full,
  output logic            empty
);

  // Pointers are exactly RN_W bits so they wrap 15 -> 0 without extra logic;
  // count is kept separately so full and empty stay distinguishable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
`ifdef ROB_FLUSH_EN
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
`endif
    end else begin
      if (alloc_fire) begin
        tail <= tail + 1'b1;
      end
      if (retire_fire) begin
        head <= head + 1'b1;
      end
      case ({alloc_fire, retire_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == ROB_FULL_COUNT);
  assign empty = (count == '0);

endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular ROB. Allocates in program order, marks entries
// complete from any of NUM_FU completion ports in any order, and retires the
// head entry in order toward the free list and commit/store path.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   flush                           (only with ROB_FLUSH_EN) discard all entries
//   alloc_valid / alloc_ready       allocation handshake from rename
//   alloc_preg_dst, alloc_old_preg_dst, alloc_reg_write, alloc_mem_write
//                                   fields of the instruction being allocated
//   alloc_rob_num                   ROB number given to it (current tail)
//   cmp_valid, cmp_rob_num, cmp_data per-FU completion; FU i at slice i
//   retire_valid / retire_ready     retire handshake for the head entry
//   retire_rob_num, retire_preg_dst, retire_old_preg_dst, retire_data,
//   retire_reg_write, retire_mem_write  head entry fields
//   count, empty, full              occupancy status
//
// Optional feature macro: ROB_FLUSH_EN
module reorder_buffer
  import Types::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef ROB_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [PREG_W-1:0]        alloc_preg_dst,
  input  logic [PREG_W-1:0]        alloc_old_preg_dst,
  input  logic                     alloc_reg_write,
  input  logic                     alloc_mem_write,
  output logic [RN_W-1:0]          alloc_rob_num,
  input  logic [NUM_FU-1:0]        cmp_valid,
  input  logic [NUM_FU*RN_W-1:0]   cmp_rob_num,
  input  logic [NUM_FU*DATA_W-1:0] cmp_data,
  output logic                     retire_valid,
  input  logic                     retire_ready,
  output logic [RN_W-1:0]          retire_rob_num,
  output logic [PREG_W-1:0]        retire_preg_dst,
  output logic [PREG_W-1:0]        retire_old_preg_dst,
  output logic [DATA_W-1:0]        retire_data,
  output logic                     retire_reg_write,
  output logic                     retire_mem_write,
  output logic [RN_W:0]            count,
  output logic                     empty,
  output logic                     full
);

  rob_row_struct        rob [ROB_DEPTH];
  complete_stage_struct cmp_port [NUM_FU];
  logic [RN_W-1:0]      head;
  logic [RN_W-1:0]      tail;
  logic                 alloc_fire;
  logic                 retire_fire;
  logic                 flush_active;

`ifdef ROB_FLUSH_EN
  assign flush_active = flush;
`else
  assign flush_active = 1'b0;
`endif

  rob_ptr_ctrl u_ptr (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef ROB_FLUSH_EN
    .flush       (flush),
`endif
    .alloc_fire  (alloc_fire),
    .retire_fire (retire_fire),
    .head        (head),
    .tail        (tail),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  // Unpack the flat completion buses into one record per functional unit.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      cmp_port[i].ROBNumber = cmp_rob_num[i*RN_W +: RN_W];
      cmp_port[i].FU_Result = cmp_data[i*DATA_W +: DATA_W];
    end
  end

  // Full stalls allocation even if the head retires this cycle; a flush
  // blocks both handshakes so nothing slips through during the clear.
  assign alloc_ready   = !full && !flush_active;
  assign alloc_fire    = alloc_valid && alloc_ready;
  assign alloc_rob_num = tail;

  assign retire_valid        = rob[head].valid && rob[head].complete && !flush_active;
  assign retire_fire         = retire_valid && retire_ready;
  assign retire_rob_num      = head;
  assign retire_preg_dst     = rob[head].preg_dst;
  assign retire_old_preg_dst = rob[head].old_preg_dst;
  assign retire_data         = rob[head].data;
  assign retire_reg_write    = rob[head].reg_write;
  assign retire_mem_write    = rob[head].mem_write;

  // Only valid/complete are reset; payload is meaningless until allocated.
  // Completion ports are scanned from the highest index down so that the
  // lowest-indexed FU's nonblocking write lands last and wins a collision.
  // Retire is applied after completion so its clear has the final say.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rob[i].valid    <= 1'b0;
        rob[i].complete <= 1'b0;
      end
    end else if (flush_active) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rob[i].valid    <= 1'b0;
        rob[i].complete <= 1'b0;
      end
    end else begin
      for (int i = NUM_FU - 1; i >= 0; i--) begin
        if (cmp_valid[i] && rob[cmp_port[i].ROBNumber].valid) begin
          rob[cmp_port[i].ROBNumber].complete <= 1'b1;
          rob[cmp_port[i].ROBNumber].data     <= cmp_port[i].FU_Result;
        end
      end
      if (alloc_fire) begin
        rob[tail].valid        <= 1'b1;
        rob[tail].complete     <= 1'b0;
        rob[tail].preg_dst     <= alloc_preg_dst;
        rob[tail].old_preg_dst <= alloc_old_preg_dst;
        rob[tail].reg_write    <= alloc_reg_write;
        rob[tail].mem_write    <= alloc_mem_write;
      end
      if (retire_fire) begin
        rob[head].valid    <= 1'b0;
        rob[head].complete <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed, table-driven bench for reorder_buffer.
// Inputs are driven 1 time unit after the rising edge and outputs are
// checked 2 units later, well away from the next rising edge.
// Optional feature macro: ROB_FLUSH_EN (adds the flush sequence).
module tb_reorder_buffer;

  logic        clk;
  logic        rst_n;
`ifdef ROB_FLUSH_EN
  logic        flush;
`endif
  logic        alloc_valid;
  logic        alloc_ready;
  logic [6:0]  alloc_preg_dst;
  logic [6:0]  alloc_old_preg_dst;
  logic        alloc_reg_write;
  logic        alloc_mem_write;
  logic [3:0]  alloc_rob_num;
  logic [2:0]  cmp_valid;
  logic [11:0] cmp_rob_num;
  logic [95:0] cmp_data;
  logic        retire_valid;
  logic        retire_ready;
  logic [3:0]  retire_rob_num;
  logic [6:0]  retire_preg_dst;
  logic [6:0]  retire_old_preg_dst;
  logic [31:0] retire_data;
  logic        retire_reg_write;
  logic        retire_mem_write;
  logic [4:0]  count;
  logic        empty;
  logic        full;

  int n_compared   = 0;
  int n_mismatched = 0;

  reorder_buffer dut (
    .clk                 (clk),
    .rst_n               (rst_n),
`ifdef ROB_FLUSH_EN
    .flush               (flush),
`endif
    .alloc_valid         (alloc_valid),
    .alloc_ready         (alloc_ready),
    .alloc_preg_dst      (alloc_preg_dst),
    .alloc_old_preg_dst  (alloc_old_preg_dst),
    .alloc_reg_write     (alloc_reg_write),
    .alloc_mem_write     (alloc_mem_write),
    .alloc_rob_num       (alloc_rob_num),
    .cmp_valid           (cmp_valid),
    .cmp_rob_num         (cmp_rob_num),
    .cmp_data            (cmp_data),
    .retire_valid        (retire_valid),
    .retire_ready        (retire_ready),
    .retire_rob_num      (retire_rob_num),
    .retire_preg_dst     (retire_preg_dst),
    .retire_old_preg_dst (retire_old_preg_dst),
    .retire_data         (retire_data),
    .retire_reg_write    (retire_reg_write),
    .retire_mem_write    (retire_mem_write),
    .count               (count),
    .empty               (empty),
    .full                (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [6:0]  preg;
    logic [6:0]  opreg;
    logic        rw;
    logic        mw;
    logic [2:0]  cv;
    logic [11:0] crob;
    logic [95:0] cdata;
    logic        rr;
    logic [4:0]  e_count;
    logic [3:0]  e_arob;
    logic        e_ready;
    logic        e_rv;
    logic [3:0]  e_rrob;
    logic [31:0] e_rdata;
    logic [6:0]  e_preg;
    logic [6:0]  e_old;
    logic        e_rw;
    logic        e_mw;
  } vec_t;

  vec_t vecs [10];

  logic [31:0] exp_q [$];
  logic [3:0]  exp_head;
  logic [3:0]  exp_tail;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    alloc_valid        = v.av;
    alloc_preg_dst     = v.preg;
    alloc_old_preg_dst = v.opreg;
    alloc_reg_write    = v.rw;
    alloc_mem_write    = v.mw;
    cmp_valid          = v.cv;
    cmp_rob_num        = v.crob;
    cmp_data           = v.cdata;
    retire_ready       = v.rr;
  endtask

  task automatic setIdle();
    alloc_valid        = 1'b0;
    alloc_preg_dst     = '0;
    alloc_old_preg_dst = '0;
    alloc_reg_write    = 1'b0;
    alloc_mem_write    = 1'b0;
    cmp_valid          = '0;
    cmp_rob_num        = '0;
    cmp_data           = '0;
    retire_ready       = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic completeOne(input logic [3:0] rob, input logic [31:0] data);
    cmp_valid   = 3'b001;
    cmp_rob_num = {8'd0, rob};
    cmp_data    = {64'd0, data};
  endtask

  // Asserts reset between edges and checks that outputs follow at once.
  task automatic doReset(input string tag);
    rst_n = 1'b0;
    #1;
    checkOutput({tag, "_count"}, 32'(count), 32'd0);
    checkOutput({tag, "_empty"}, 32'(empty), 32'd1);
    checkOutput({tag, "_full"}, 32'(full), 32'd0);
    checkOutput({tag, "_ready"}, 32'(alloc_ready), 32'd1);
    checkOutput({tag, "_rvalid"}, 32'(retire_valid), 32'd0);
    checkOutput({tag, "_arob"}, 32'(alloc_rob_num), 32'd0);
    setIdle();
    cycle();
    rst_n = 1'b1;
    cycle();
  endtask

  initial begin
    rst_n = 1'b0;
`ifdef ROB_FLUSH_EN
    flush = 1'b0;
`endif
    setIdle();
    #2;
    doReset("reset");

    // In-order retire of out-of-order completions.
    vecs[0] = '{1'b1, 7'd40, 7'd5, 1'b1, 1'b0, 3'b000, 12'h000, 96'h0, 1'b0,
                5'd0, 4'd0, 1'b1, 1'b0, 4'd0, 32'h0, 7'd0, 7'd0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 7'd41, 7'd6, 1'b0, 1'b1, 3'b000, 12'h000, 96'h0, 1'b0,
                5'd1, 4'd1, 1'b1, 1'b0, 4'd0, 32'h0, 7'd0, 7'd0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 7'd42, 7'd7, 1'b1, 1'b0, 3'b000, 12'h000, 96'h0, 1'b0,
                5'd2, 4'd2, 1'b1, 1'b0, 4'd0, 32'h0, 7'd0, 7'd0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 3'b010, 12'h020, {32'h0, 32'hA, 32'h0}, 1'b0,
                5'd3, 4'd3, 1'b1, 1'b0, 4'd0, 32'h0, 7'd0, 7'd0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 3'b001, 12'h001, {32'h0, 32'h0, 32'hB}, 1'b0,
                5'd3, 4'd3, 1'b1, 1'b0, 4'd0, 32'h0, 7'd0, 7'd0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 3'b100, 12'h000, {32'hC, 32'h0, 32'h0}, 1'b1,
                5'd3, 4'd3, 1'b1, 1'b0, 4'd0, 32'h0, 7'd0, 7'd0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 3'b000, 12'h000, 96'h0, 1'b1,
                5'd3, 4'd3, 1'b1, 1'b1, 4'd0, 32'hC, 7'd40, 7'd5, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 3'b000, 12'h000, 96'h0, 1'b1,
                5'd2, 4'd3, 1'b1, 1'b1, 4'd1, 32'hB, 7'd41, 7'd6, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 3'b000, 12'h000, 96'h0, 1'b1,
                5'd1, 4'd3, 1'b1, 1'b1, 4'd2, 32'hA, 7'd42, 7'd7, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 7'd0, 7'd0, 1'b0, 1'b0, 3'b000, 12'h000, 96'h0, 1'b0,
                5'd0, 4'd3, 1'b1, 1'b0, 4'd0, 32'h0, 7'd0, 7'd0, 1'b0, 1'b0};

    for (int k = 0; k < 10; k++) begin
      applyStimulus(vecs[k]);
      #2;
      checkOutput($sformatf("v%0d_count", k), 32'(count), 32'(vecs[k].e_count));
      checkOutput($sformatf("v%0d_empty", k), 32'(empty), 32'(vecs[k].e_count == 5'd0));
      checkOutput($sformatf("v%0d_arob", k), 32'(alloc_rob_num), 32'(vecs[k].e_arob));
      checkOutput($sformatf("v%0d_ready", k), 32'(alloc_ready), 32'(vecs[k].e_ready));
      checkOutput($sformatf("v%0d_rvalid", k), 32'(retire_valid), 32'(vecs[k].e_rv));
      if (vecs[k].e_rv) begin
        checkOutput($sformatf("v%0d_rrob", k), 32'(retire_rob_num), 32'(vecs[k].e_rrob));
        checkOutput($sformatf("v%0d_rdata", k), retire_data, vecs[k].e_rdata);
        checkOutput($sformatf("v%0d_rpreg", k), 32'(retire_preg_dst), 32'(vecs[k].e_preg));
        checkOutput($sformatf("v%0d_rold", k), 32'(retire_old_preg_dst), 32'(vecs[k].e_old));
        checkOutput($sformatf("v%0d_rrw", k), 32'(retire_reg_write), 32'(vecs[k].e_rw));
        checkOutput($sformatf("v%0d_rmw", k), 32'(retire_mem_write), 32'(vecs[k].e_mw));
      end
      cycle();
    end
    setIdle();

    // Fill to full, then check that a full ROB stalls alloc for a cycle.
    doReset("reset2");
    for (int k = 0; k < 16; k++) begin
      alloc_valid        = 1'b1;
      alloc_preg_dst     = 7'(k + 16);
      alloc_old_preg_dst = 7'(k);
      alloc_reg_write    = 1'b1;
      #2;
      checkOutput($sformatf("fill%0d_arob", k), 32'(alloc_rob_num), 32'(k));
      cycle();
    end
    setIdle();
    #2;
    checkOutput("full_count", 32'(count), 32'd16);
    checkOutput("full_flag", 32'(full), 32'd1);
    checkOutput("full_ready", 32'(alloc_ready), 32'd0);
    checkOutput("full_arob", 32'(alloc_rob_num), 32'd0);
    completeOne(4'd0, 32'h55);
    cycle();
    setIdle();
    alloc_valid        = 1'b1;
    alloc_preg_dst     = 7'd100;
    alloc_old_preg_dst = 7'd99;
    retire_ready       = 1'b1;
    #2;
    checkOutput("stall_rvalid", 32'(retire_valid), 32'd1);
    checkOutput("stall_rdata", retire_data, 32'h55);
    checkOutput("stall_ready", 32'(alloc_ready), 32'd0);
    cycle();
    #2;
    checkOutput("wrap_count", 32'(count), 32'd15);
    checkOutput("wrap_ready", 32'(alloc_ready), 32'd1);
    checkOutput("wrap_arob", 32'(alloc_rob_num), 32'd0);
    checkOutput("wrap_rvalid", 32'(retire_valid), 32'd0);
    cycle();
    setIdle();
    #2;
    checkOutput("refull_count", 32'(count), 32'd16);
    checkOutput("refull_flag", 32'(full), 32'd1);

    // Collision: all FUs name ROB 4 in the same cycle; FU0 must win.
    cmp_valid   = 3'b111;
    cmp_rob_num = {4'd3, 4'd2, 4'd1};
    cmp_data    = {32'd13, 32'd12, 32'd11};
    cycle();
    cmp_rob_num = {4'd4, 4'd4, 4'd4};
    cmp_data    = {32'd3, 32'd2, 32'd1};
    cycle();
    setIdle();
    retire_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      #2;
      checkOutput($sformatf("coll%0d_rvalid", k), 32'(retire_valid), 32'd1);
      checkOutput($sformatf("coll%0d_rrob", k), 32'(retire_rob_num), 32'(k));
      checkOutput($sformatf("coll%0d_rdata", k), retire_data, (k == 4) ? 32'd1 : 32'(k + 10));
      checkOutput($sformatf("coll%0d_rold", k), 32'(retire_old_preg_dst), 32'(k));
      cycle();
    end
    setIdle();

    // Steady state at count 8 across the pointer wrap.
    doReset("reset3");
    for (int k = 0; k < 8; k++) begin
      alloc_valid        = 1'b1;
      alloc_preg_dst     = 7'(k);
      alloc_old_preg_dst = 7'(k + 64);
      if (k > 0) begin
        completeOne(4'(k - 1), 32'h1000 + 32'(k - 1));
        exp_q.push_back(32'h1000 + 32'(k - 1));
      end
      cycle();
      cmp_valid = '0;
    end
    alloc_valid = 1'b0;
    completeOne(4'd7, 32'h1007);
    exp_q.push_back(32'h1007);
    cycle();
    setIdle();
    exp_head = 4'd0;
    exp_tail = 4'd8;
    for (int i = 0; i < 40; i++) begin
      alloc_valid        = 1'b1;
      alloc_preg_dst     = 7'(i);
      alloc_old_preg_dst = 7'(i + 1);
      retire_ready       = 1'b1;
      if (i > 0) begin
        completeOne(exp_tail - 4'd1, 32'h2000 + 32'(i));
        exp_q.push_back(32'h2000 + 32'(i));
      end else begin
        cmp_valid = '0;
      end
      #2;
      checkOutput($sformatf("ss%0d_rvalid", i), 32'(retire_valid), 32'd1);
      checkOutput($sformatf("ss%0d_rrob", i), 32'(retire_rob_num), 32'(exp_head));
      checkOutput($sformatf("ss%0d_rdata", i), retire_data, exp_q[0]);
      checkOutput($sformatf("ss%0d_count", i), 32'(count), 32'd8);
      checkOutput($sformatf("ss%0d_arob", i), 32'(alloc_rob_num), 32'(exp_tail));
      void'(exp_q.pop_front());
      cycle();
      exp_head = exp_head + 4'd1;
      exp_tail = exp_tail + 4'd1;
    end
    setIdle();
    for (int k = 0; k < 3; k++) begin
      #2;
      checkOutput($sformatf("hold%0d_rvalid", k), 32'(retire_valid), 32'd1);
      checkOutput($sformatf("hold%0d_rrob", k), 32'(retire_rob_num), 32'(exp_head));
      checkOutput($sformatf("hold%0d_rdata", k), retire_data, exp_q[0]);
      checkOutput($sformatf("hold%0d_count", k), 32'(count), 32'd8);
      cycle();
    end

    // Grow to 10 entries, then reset asynchronously mid-cycle.
    alloc_valid = 1'b1;
    cycle();
    cycle();
    #2;
    checkOutput("pre_rst_count", 32'(count), 32'd10);
    doReset("midrst");
    #2;
    checkOutput("post_rst_count", 32'(count), 32'd0);

`ifdef ROB_FLUSH_EN
    // Flush wins over a same-cycle allocation and retire.
    for (int k = 0; k < 3; k++) begin
      alloc_valid = 1'b1;
      cycle();
    end
    alloc_valid = 1'b0;
    completeOne(4'd0, 32'h77);
    cycle();
    setIdle();
    alloc_valid  = 1'b1;
    retire_ready = 1'b1;
    flush        = 1'b1;
    #2;
    checkOutput("flush_ready", 32'(alloc_ready), 32'd0);
    checkOutput("flush_rvalid", 32'(retire_valid), 32'd0);
    cycle();
    flush = 1'b0;
    setIdle();
    #2;
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_empty", 32'(empty), 32'd1);
    checkOutput("flush_arob", 32'(alloc_rob_num), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular reorder buffer that consumes the results written by the complete stage.
- Allocates one entry per cycle, in program order, for each renamed instruction.
- Marks entries complete when functional-unit results arrive, in any order.
- Retires the head entry in order, driving the physical-register free list and the architectural commit/store path.

Parameters:
- DEPTH, 16, number of ROB entries; power of two; ROB number width RN_W = log2(DEPTH) = 4.
- PREG_W, 7, physical register address width (p_reg).
- NUM_FU, 3, number of completion ports (FU1, FU2, FU3-mem).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- alloc_valid  input  1  rename presents an instruction.
- alloc_ready  output  1  entry available (not full).
- alloc_preg_dst  input  PREG_W  new destination preg.
- alloc_old_preg_dst  input  PREG_W  previous mapping of the destination.
- alloc_reg_write  input  1  instruction writes a register.
- alloc_mem_write  input  1  instruction is a store.
- alloc_rob_num  output  RN_W  ROB number assigned (equals tail; combinational).
- cmp_valid  input  NUM_FU  per-FU completion strobe.
- cmp_rob_num  input  NUM_FU*RN_W  per-FU ROB number; FU i occupies bits [i*RN_W +: RN_W].
- cmp_data  input  NUM_FU*32  per-FU result word.
- retire_valid  output  1  head entry valid and complete.
- retire_ready  input  1  commit side accepts the head entry.
- retire_rob_num, retire_preg_dst, retire_old_preg_dst  output  RN_W/PREG_W/PREG_W  head entry fields.
- retire_data  output  32  head result.
- retire_reg_write, retire_mem_write  output  1  head entry flags.
- count  output  RN_W+1  occupied entries, 0..DEPTH.
- empty, full  output  1  status flags.

Behaviour:
- Storage: per entry valid, complete, preg_dst, old_preg_dst, data, reg_write, mem_write.
- Pointers: head/tail are RN_W bits and wrap naturally (15+1 -> 0). count is registered.
- Reset (asynchronous, rst_n=0):
  - head=tail=count=0; all valid and complete bits cleared.
  - Outputs: alloc_ready=1, empty=1, full=0, retire_valid=0, alloc_rob_num=0.
  - Entry payload registers need no reset.
  - Reset asserted mid-operation discards all in-flight entries.
- Allocation fires when alloc_valid && alloc_ready. On the clock edge:
  - entry[tail] is written with valid=1, complete=0 and the alloc fields.
  - tail is incremented.
- alloc_ready = !full. It does not anticipate a same-cycle retire; a full ROB stalls one cycle.
- Completion: for each FU i with cmp_valid[i], on the edge entry[cmp_rob_num[i]] gets complete=1 and data=cmp_data[i].
  - Completion to an entry with valid=0 is ignored.
  - Two FUs naming the same entry in one cycle: lowest FU index wins.
  - Completion to an entry allocated in the same cycle is illegal (that ROB number has not yet been issued).
- Retire:
  - retire_valid = entry[head].valid && entry[head].complete.
  - All retire_* outputs are combinational from entry[head].
  - On retire_valid && retire_ready: entry[head].valid and complete are cleared and head is incremented.
  - One retire per cycle.
  - A result completing the head becomes visible on retire_valid in the next cycle (one-cycle minimum complete-to-retire latency).
- Simultaneous alloc and retire: count is unchanged, both pointers advance. This is legal at count=DEPTH-1 and any lower count.
- Status: full = (count==DEPTH); empty = (count==0).

Optional Feature:
- Macro: ROB_FLUSH_EN.
- With the macro defined, an extra input flush (1 bit) is added. Asserting it synchronously clears:
  - all valid/complete bits;
  - head, tail and count (all to 0).
- Flush has priority over same-cycle alloc, complete and retire.
- While flush=1: retire_valid=0 and alloc_ready=0.
- Without the macro: no flush port; entries leave only by retire.

Decomposition:
- Add to package Types:
  - typedef rob_num_t (logic [3:0]);
  - localparam ROB_DEPTH=16;
  - localparam NUM_FU=3.
- Reuse rob_row_struct as the entry storage type.
- Reuse complete_stage_struct fields (ROBNumber, FU_Result) for the completion-port mapping.
- Natural sub-module: rob_ptr_ctrl, which holds the head/tail/count registers and the full/empty logic. The entry array and the complete/retire muxing stay in the top module.

Test Plan:
- Reset then idle: count=0, empty=1, alloc_ready=1, retire_valid=0. Alloc preg 7'd40 / old 7'd5 -> alloc_rob_num=0; next cycle count=1, retire_valid=0.
- Alloc ROB 0,1,2; complete 2 then 1 via FU1/FU0 (data 32'hA, 32'hB) -> no retire until ROB 0 completes with 32'hC. Then three consecutive retires in order 0,1,2 with data C,B,A; old_preg values freed in order.
- Fill 16 entries -> full=1, alloc_ready=0, count=16. Complete and retire head with retire_ready=1 while alloc_valid=1 -> alloc waits one cycle, then succeeds with alloc_rob_num=0 (tail wraps).
- All three FUs complete ROB 4 in one cycle (data 1, 2, 3) -> entry 4 retires with data 1 (FU0 wins).
- Steady state at count=8 with alloc and retire every cycle for 40 cycles, crossing the 15->0 wrap -> count stays 8, ROB numbers wrap cleanly. Hold retire_ready=0 for 3 cycles -> head outputs stable.
- rst_n pulsed low asynchronously mid-stream with count=10 -> outputs return to reset values immediately. Under ROB_FLUSH_EN, flush with alloc_valid=1 -> count=0 next cycle and no allocation performed.
